// File: rtl/l2_output_encoder.sv
// Outbound L2 coherence message encoder: buffers request and response messages
// in two independent first-word-fall-through FIFOs and drives them toward the NoC.

module l2_oe_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_afull,
  output logic         o_drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_wr;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_afull = (r_count >= CW'(DEPTH - 1));
  assign w_pop   = o_valid && i_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign w_wr    = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && o_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data = o_valid ? r_mem[r_rd_ptr] : '0;
endmodule

module l2_output_encoder #(
  parameter int LINE_ADDR_BITS = 28,
  parameter int LINE_BITS      = 128,
  parameter int WORD_MASK_BITS = 2,
  parameter int COH_MSG_BITS   = 5,
  parameter int REQ_ID_BITS    = 4,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_push,
  input  logic [COH_MSG_BITS-1:0]   req_coh_msg,
  input  logic                      req_hprot,
  input  logic [LINE_ADDR_BITS-1:0] req_addr,
  input  logic [LINE_BITS-1:0]      req_line,
  input  logic [WORD_MASK_BITS-1:0] req_word_mask,
  output logic                      req_full,
  output logic                      req_afull,
  output logic                      l2_req_out_valid,
  input  logic                      l2_req_out_ready,
  output logic [COH_MSG_BITS-1:0]   l2_req_out_coh_msg,
  output logic                      l2_req_out_hprot,
  output logic [LINE_ADDR_BITS-1:0] l2_req_out_addr,
  output logic [LINE_BITS-1:0]      l2_req_out_line,
  output logic [WORD_MASK_BITS-1:0] l2_req_out_word_mask,
  input  logic                      rsp_push,
  input  logic [COH_MSG_BITS-1:0]   rsp_coh_msg,
  input  logic [REQ_ID_BITS-1:0]    rsp_req_id,
  input  logic                      rsp_to_req,
  input  logic [LINE_ADDR_BITS-1:0] rsp_addr,
  input  logic [LINE_BITS-1:0]      rsp_line,
  input  logic [WORD_MASK_BITS-1:0] rsp_word_mask,
  output logic                      rsp_full,
  output logic                      rsp_afull,
  output logic                      l2_rsp_out_valid,
  input  logic                      l2_rsp_out_ready,
  output logic [COH_MSG_BITS-1:0]   l2_rsp_out_coh_msg,
  output logic [REQ_ID_BITS-1:0]    l2_rsp_out_req_id,
  output logic                      l2_rsp_out_to_req,
  output logic [LINE_ADDR_BITS-1:0] l2_rsp_out_addr,
  output logic [LINE_BITS-1:0]      l2_rsp_out_line,
  output logic [WORD_MASK_BITS-1:0] l2_rsp_out_word_mask,
  output logic                      idle,
  output logic                      overflow
);
  localparam int REQ_W = COH_MSG_BITS + 1 + LINE_ADDR_BITS + LINE_BITS + WORD_MASK_BITS;
  localparam int RSP_W = COH_MSG_BITS + REQ_ID_BITS + 1 + LINE_ADDR_BITS + LINE_BITS + WORD_MASK_BITS;

  logic [REQ_W-1:0] w_req_in;
  logic [REQ_W-1:0] w_req_head;
  logic [RSP_W-1:0] w_rsp_in;
  logic [RSP_W-1:0] w_rsp_head;
  logic             w_req_drop;
  logic             w_rsp_drop;
  logic             r_overflow;

  assign w_req_in = {req_coh_msg, req_hprot, req_addr, req_line, req_word_mask};
  assign w_rsp_in = {rsp_coh_msg, rsp_req_id, rsp_to_req, rsp_addr, rsp_line, rsp_word_mask};

  l2_oe_fifo #(.W(REQ_W), .DEPTH(DEPTH)) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (req_push),
    .i_data  (w_req_in),
    .i_ready (l2_req_out_ready),
    .o_valid (l2_req_out_valid),
    .o_data  (w_req_head),
    .o_full  (req_full),
    .o_afull (req_afull),
    .o_drop  (w_req_drop)
  );

  l2_oe_fifo #(.W(RSP_W), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (rsp_push),
    .i_data  (w_rsp_in),
    .i_ready (l2_rsp_out_ready),
    .o_valid (l2_rsp_out_valid),
    .o_data  (w_rsp_head),
    .o_full  (rsp_full),
    .o_afull (rsp_afull),
    .o_drop  (w_rsp_drop)
  );

  assign {l2_req_out_coh_msg, l2_req_out_hprot, l2_req_out_addr,
          l2_req_out_line, l2_req_out_word_mask} = w_req_head;
  assign {l2_rsp_out_coh_msg, l2_rsp_out_req_id, l2_rsp_out_to_req, l2_rsp_out_addr,
          l2_rsp_out_line, l2_rsp_out_word_mask} = w_rsp_head;

  assign idle = !l2_req_out_valid && !l2_rsp_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_overflow <= 1'b0;
    else if (w_req_drop || w_rsp_drop) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
endmodule

// File: tb/tb_l2_output_encoder.sv
// Scoreboard bench for l2_output_encoder: a queue-based model predicts accepted
// messages, and a negedge monitor compares every presented head against it.

module tb_l2_output_encoder;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]   coh;
    logic         hprot;
    logic [27:0]  addr;
    logic [127:0] line;
    logic [1:0]   wm;
  } req_t;

  typedef struct packed {
    logic [4:0]   coh;
    logic [3:0]   id;
    logic         to_req;
    logic [27:0]  addr;
    logic [127:0] line;
    logic [1:0]   wm;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic req_push, req_hprot, req_full, req_afull;
  logic [4:0] req_coh_msg;
  logic [27:0] req_addr;
  logic [127:0] req_line;
  logic [1:0] req_word_mask;
  logic l2_req_out_valid, l2_req_out_ready, l2_req_out_hprot;
  logic [4:0] l2_req_out_coh_msg;
  logic [27:0] l2_req_out_addr;
  logic [127:0] l2_req_out_line;
  logic [1:0] l2_req_out_word_mask;
  logic rsp_push, rsp_to_req, rsp_full, rsp_afull;
  logic [4:0] rsp_coh_msg;
  logic [3:0] rsp_req_id;
  logic [27:0] rsp_addr;
  logic [127:0] rsp_line;
  logic [1:0] rsp_word_mask;
  logic l2_rsp_out_valid, l2_rsp_out_ready, l2_rsp_out_to_req;
  logic [4:0] l2_rsp_out_coh_msg;
  logic [3:0] l2_rsp_out_req_id;
  logic [27:0] l2_rsp_out_addr;
  logic [127:0] l2_rsp_out_line;
  logic [1:0] l2_rsp_out_word_mask;
  logic idle, overflow;

  l2_output_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_push(req_push), .req_coh_msg(req_coh_msg), .req_hprot(req_hprot),
    .req_addr(req_addr), .req_line(req_line), .req_word_mask(req_word_mask),
    .req_full(req_full), .req_afull(req_afull),
    .l2_req_out_valid(l2_req_out_valid), .l2_req_out_ready(l2_req_out_ready),
    .l2_req_out_coh_msg(l2_req_out_coh_msg), .l2_req_out_hprot(l2_req_out_hprot),
    .l2_req_out_addr(l2_req_out_addr), .l2_req_out_line(l2_req_out_line),
    .l2_req_out_word_mask(l2_req_out_word_mask),
    .rsp_push(rsp_push), .rsp_coh_msg(rsp_coh_msg), .rsp_req_id(rsp_req_id),
    .rsp_to_req(rsp_to_req), .rsp_addr(rsp_addr), .rsp_line(rsp_line),
    .rsp_word_mask(rsp_word_mask), .rsp_full(rsp_full), .rsp_afull(rsp_afull),
    .l2_rsp_out_valid(l2_rsp_out_valid), .l2_rsp_out_ready(l2_rsp_out_ready),
    .l2_rsp_out_coh_msg(l2_rsp_out_coh_msg), .l2_rsp_out_req_id(l2_rsp_out_req_id),
    .l2_rsp_out_to_req(l2_rsp_out_to_req), .l2_rsp_out_addr(l2_rsp_out_addr),
    .l2_rsp_out_line(l2_rsp_out_line), .l2_rsp_out_word_mask(l2_rsp_out_word_mask),
    .idle(idle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most DEPTH messages per channel.
  req_t req_q[$];
  rsp_t rsp_q[$];
  int   req_cnt = 0;
  int   rsp_cnt = 0;
  bit   exp_ovf = 0;

  task automatic model_clear();
    req_q.delete();
    rsp_q.delete();
    req_cnt = 0;
    rsp_cnt = 0;
    exp_ovf = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      bit rq_pop, rs_pop;
      rq_pop = (req_cnt > 0) && l2_req_out_ready;
      rs_pop = (rsp_cnt > 0) && l2_rsp_out_ready;
      if (rq_pop) req_cnt--;
      if (rs_pop) rsp_cnt--;
      if (req_push) begin
        if (req_cnt < DEPTH) begin
          req_q.push_back('{req_coh_msg, req_hprot, req_addr, req_line, req_word_mask});
          req_cnt++;
        end else exp_ovf = 1;
      end
      if (rsp_push) begin
        if (rsp_cnt < DEPTH) begin
          rsp_q.push_back('{rsp_coh_msg, rsp_req_id, rsp_to_req, rsp_addr, rsp_line, rsp_word_mask});
          rsp_cnt++;
        end else exp_ovf = 1;
      end
    end
  end

  // Monitor: compares status and head every cycle; retires the head on a handshake.
  always @(negedge clk) begin
    if (!rst) begin
      req_t rq_act;
      rsp_t rs_act;
      rq_act = '{l2_req_out_coh_msg, l2_req_out_hprot, l2_req_out_addr,
                 l2_req_out_line, l2_req_out_word_mask};
      rs_act = '{l2_rsp_out_coh_msg, l2_rsp_out_req_id, l2_rsp_out_to_req,
                 l2_rsp_out_addr, l2_rsp_out_line, l2_rsp_out_word_mask};
      check("req_valid", l2_req_out_valid, req_cnt != 0);
      check("req_full",  req_full,  req_cnt == DEPTH);
      check("req_afull", req_afull, req_cnt >= DEPTH - 1);
      check("rsp_valid", l2_rsp_out_valid, rsp_cnt != 0);
      check("rsp_full",  rsp_full,  rsp_cnt == DEPTH);
      check("rsp_afull", rsp_afull, rsp_cnt >= DEPTH - 1);
      check("idle",      idle, (req_cnt == 0) && (rsp_cnt == 0));
      check("overflow",  overflow, exp_ovf);
      if (req_q.size() != 0) begin
        check("req_head", rq_act, req_q[0]);
        if (l2_req_out_ready) void'(req_q.pop_front());
      end else check("req_head_zero", rq_act, '0);
      if (rsp_q.size() != 0) begin
        check("rsp_head", rs_act, rsp_q[0]);
        if (l2_rsp_out_ready) void'(rsp_q.pop_front());
      end else check("rsp_head_zero", rs_act, '0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic push, input logic [4:0] coh, input logic [27:0] addr);
    req_push      = push;
    req_coh_msg   = coh;
    req_hprot     = addr[0];
    req_addr      = addr;
    req_line      = {4{$urandom()}};
    req_word_mask = 2'($urandom());
  endtask

  task automatic drive_rsp_rand(input logic push);
    rsp_push      = push;
    rsp_coh_msg   = 5'($urandom());
    rsp_req_id    = 4'($urandom());
    rsp_to_req    = 1'($urandom());
    rsp_addr      = 28'($urandom());
    rsp_line      = {4{$urandom()}};
    rsp_word_mask = 2'($urandom());
  endtask

  initial begin
    rst = 1'b1;
    drive_req(1'b0, '0, '0);
    drive_rsp_rand(1'b0);
    l2_req_out_ready = 1'b0;
    l2_rsp_out_ready = 1'b0;
    #1;
    check("rst_req_valid", l2_req_out_valid, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_full", {req_full, req_afull, rsp_full, rsp_afull}, 4'b0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Single request with ready held high.
    l2_req_out_ready = 1'b1;
    drive_req(1'b1, 5'd3, 28'h0ABCDEF);
    cyc();
    drive_req(1'b0, '0, '0);
    check("t1_valid_n1", l2_req_out_valid, 1'b1);
    check("t1_addr_n1",  l2_req_out_addr, 28'h0ABCDEF);
    cyc();
    check("t1_idle_n2", idle, 1'b1);

    // Fill with ready low, one dropped push, then drain in order.
    l2_req_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive_req(1'b1, 5'd1, 28'(i));
      cyc();
      if (i == 3) check("t2_afull_after3", {req_afull, req_full}, 2'b10);
      if (i == 4) check("t2_full_after4",  {req_afull, req_full}, 2'b11);
    end
    drive_req(1'b0, '0, '0);
    check("t2_overflow", overflow, 1'b1);
    l2_req_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t2_drain_addr", l2_req_out_addr, 28'(i));
      cyc();
    end
    check("t2_drained", l2_req_out_valid, 1'b0);

    // Full FIFO with simultaneous push and pop.
    l2_req_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_req(1'b1, 5'd2, 28'(i));
      cyc();
    end
    l2_req_out_ready = 1'b1;
    drive_req(1'b1, 5'd2, 28'd9);
    cyc();
    drive_req(1'b0, '0, '0);
    check("t3_still_full", req_full, 1'b1);
    repeat (4) cyc();
    check("t3_empty", l2_req_out_valid, 1'b0);

    // Response held under back-pressure.
    rsp_push = 1'b1; rsp_coh_msg = 5'd7; rsp_req_id = 4'd5; rsp_to_req = 1'b1;
    rsp_addr = 28'h1234567; rsp_line = {4{32'hCAFE_F00D}}; rsp_word_mask = 2'b11;
    cyc();
    drive_rsp_rand(1'b0);
    repeat (3) cyc();
    check("t4_req_id_held", {l2_rsp_out_valid, l2_rsp_out_to_req, l2_rsp_out_req_id}, {2'b11, 4'd5});
    l2_rsp_out_ready = 1'b1;
    cyc();
    check("t4_done", l2_rsp_out_valid, 1'b0);

    // Concurrent random traffic on both channels.
    for (int i = 0; i < 800; i++) begin
      drive_req(1'($urandom_range(0, 99) < 45), 5'($urandom()), 28'($urandom()));
      drive_rsp_rand(1'($urandom_range(0, 99) < 45));
      l2_req_out_ready = 1'($urandom_range(0, 99) < 50);
      l2_rsp_out_ready = 1'($urandom_range(0, 99) < 50);
      cyc();
    end
    drive_req(1'b0, '0, '0);
    drive_rsp_rand(1'b0);
    l2_req_out_ready = 1'b1;
    l2_rsp_out_ready = 1'b1;
    for (int i = 0; i < 20 && !idle; i++) cyc();
    check("t5_idle_after_drain", idle, 1'b1);
    check("t5_queues_empty", req_q.size() + rsp_q.size(), 0);

    // Reset with entries queued (overflow forced first so its clearing is visible).
    l2_req_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b1, 5'd4, 28'(16 + i));
      cyc();
    end
    drive_req(1'b0, '0, '0);
    l2_req_out_ready = 1'b1;
    cyc();
    l2_req_out_ready = 1'b0;
    check("t6_pre_rst", {overflow, req_afull}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", l2_req_out_valid, 1'b0);
    check("t6_rst_idle",  idle, 1'b1);
    check("t6_rst_ovf",   overflow, 1'b0);
    model_clear();
    cyc();
    rst = 1'b0;
    drive_req(1'b1, 5'd6, 28'h0000042);
    cyc();
    drive_req(1'b0, '0, '0);
    check("t6_new_alone", {l2_req_out_valid, req_afull, l2_req_out_addr}, {2'b10, 28'h0000042});
    l2_req_out_ready = 1'b1;
    cyc();
    check("t6_new_popped", l2_req_out_valid, 1'b0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
